// File: rtl/cambus_pkg.sv
// rtl/cambus_pkg.sv - shared cambus constants, timing defaults and state enum
package cambus_pkg;

  localparam int PIX_W = 12;
  localparam int CNT_W = 9;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_ACTIVE    = 320;
  localparam int DEF_H_TOTAL     = 400;
  localparam int DEF_HSYNC_LEN   = 32;
  localparam int DEF_V_ACTIVE    = 256;
  localparam int DEF_V_TOTAL     = 262;
  localparam int DEF_VSYNC_LINES = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cam_state_e;

  // Line 0 is blank; visible lines are 1..v_active.
  function automatic logic is_visible(input logic [CNT_W-1:0] h,
                                      input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] h_active,
                                      input logic [CNT_W-1:0] v_active);
    return (h < h_active) && (v != '0) && (v <= v_active);
  endfunction

endpackage

// File: rtl/cambus_timing.sv
// rtl/cambus_timing.sv - pixel clock divider and h/v position counters
module cambus_timing
  import cambus_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic             tick,
  output logic             cam_clk,
  output logic [CNT_W-1:0] h_next,
  output logic [CNT_W-1:0] v_next,
  output logic             v_wrap
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;

  assign tick    = (div_cnt == DIV_LAST);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;
  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = h_wrap && (v_cnt == V_LAST);
  assign h_next  = h_wrap ? '0 : h_cnt + 1'b1;
  assign v_next  = v_wrap ? '0 : (h_wrap ? v_cnt + 1'b1 : v_cnt);

  // cam_clk is registered from the next divider value so it mirrors div_cnt exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      cam_clk <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= div_nxt;
      cam_clk <= (div_nxt >= DIV_HALF);
      if (tick && advance) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
      end
    end
  end

endmodule

// File: rtl/cambus_gen.sv
// rtl/cambus_gen.sv - camera bus transmitter; CAMBUS_GEN_TEST_PATTERN_EN enables the internal test pattern
module cambus_gen
  import cambus_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int HSYNC_LEN   = DEF_HSYNC_LEN,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             show_test_pattern,
  input  logic             underflow_clr,
  output logic             cam_clk,
  output logic [PIX_W-1:0] cam_pixel,
  output logic             cam_hsync,
  output logic             cam_vsync,
  output logic             frame_start,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSYNC_C = CNT_W'(HSYNC_LEN);
  localparam logic [CNT_W-1:0] VSYNC_C = CNT_W'(VSYNC_LINES);

  cam_state_e       state;
  cam_state_e       state_nxt;
  logic             tick;
  logic             v_wrap;
  logic             run;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             pattern_sel;
  logic             launch;
  logic             stop;
  logic             launch_vis;
  logic             launch_first;
  logic [CNT_W-1:0] launch_h;
  logic [CNT_W-1:0] launch_v;
  logic [PIX_W-1:0] pattern_pix;

`ifdef CAMBUS_GEN_TEST_PATTERN_EN
  assign pattern_sel = show_test_pattern;
`else
  logic unused_show_test_pattern;
  assign unused_show_test_pattern = show_test_pattern;
  assign pattern_sel = 1'b0;
`endif

  assign run = (state == ST_RUN);

  cambus_timing #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .advance (run),
    .tick    (tick),
    .cam_clk (cam_clk),
    .h_next  (h_next),
    .v_next  (v_next),
    .v_wrap  (v_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // enable is only looked at on a frame boundary, so frames are never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (tick && enable) state_nxt = ST_RUN;
      ST_RUN:  if (tick && v_wrap && !enable) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    launch   = 1'b0;
    stop     = 1'b0;
    launch_h = '0;
    launch_v = '0;
    case (state)
      ST_IDLE: launch = tick && enable;
      ST_RUN: begin
        launch_h = h_next;
        launch_v = v_next;
        if (tick) begin
          if (v_wrap && !enable) stop = 1'b1;
          else                   launch = 1'b1;
        end
      end
      default: ;
    endcase
    launch_vis   = is_visible(launch_h, launch_v, H_ACT_C, V_ACT_C);
    pix_ready    = launch && launch_vis && !pattern_sel;
    launch_first = launch && (launch_h == '0) && (launch_v == '0);
    pattern_pix  = {launch_v[5:0], launch_h[5:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_pixel   <= '0;
      cam_hsync   <= 1'b0;
      cam_vsync   <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= launch_first;
      if (launch) begin
        cam_hsync <= (launch_h < HSYNC_C);
        cam_vsync <= (launch_v < VSYNC_C);
        if (!launch_vis)     cam_pixel <= '0;
        else if (pattern_sel) cam_pixel <= pattern_pix;
        else if (pix_valid)  cam_pixel <= pix_data;
        else                 cam_pixel <= '0;
      end else if (stop) begin
        cam_hsync <= 1'b0;
        cam_vsync <= 1'b0;
        cam_pixel <= '0;
      end
      // A new starvation event takes priority over a clear in the same cycle.
      underflow <= (pix_ready && !pix_valid) || (underflow && !underflow_clr);
    end
  end

endmodule

// File: tb/tb_cambus_gen.sv
// tb/tb_cambus_gen.sv - self-checking bench for cambus_gen with reduced frame geometry
module tb_cambus_gen;

  localparam int D     = 4;
  localparam int HA    = 10;
  localparam int HT    = 16;
  localparam int HS    = 3;
  localparam int VA    = 6;
  localparam int VT    = 9;
  localparam int VS    = 2;
  localparam int FRAME = HT * VT;
`ifdef CAMBUS_GEN_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, pix_valid, pix_ready, show_test_pattern, underflow_clr;
  logic [11:0] pix_data, cam_pixel;
  logic        cam_clk, cam_hsync, cam_vsync, frame_start, underflow;

  cambus_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_LEN(HS),
    .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_LINES(VS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .show_test_pattern(show_test_pattern), .underflow_clr(underflow_clr),
    .cam_clk(cam_clk), .cam_pixel(cam_pixel), .cam_hsync(cam_hsync), .cam_vsync(cam_vsync),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; bit hs; bit vs; bit vis; int off;
  } probe_t;
  probe_t tbl [10];

  int checks = 0, errors = 0;
  // reference model: running flag plus linear position within the frame
  int t, m_pos;
  bit m_run, e_hs, e_vs, e_fs, e_uf;
  logic [11:0] e_pix;
  // stimulus controls
  bit g_en, g_stp, g_clr_rand, g_clr_now, clr_on_drop, inc_data;
  int g_valid_mode, drop_pos;
  logic [11:0] data_ctr, base;
  // observation counters
  int cyc, fs_cnt, last_fs, fs_period, rdy_cnt, hs_cyc, vs_cyc, ck_rise, since_fs, probe_hits;
  bit probe_on;
  logic prev_ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit vis(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h < HA) && (v >= 1) && (v <= VA);
  endfunction

  task automatic model_reset();
    t = 0; m_pos = 0; m_run = 0;
    e_hs = 0; e_vs = 0; e_fs = 0; e_uf = 0; e_pix = '0;
    prev_ck = 0; since_fs = -1000000;
  endtask

  task automatic step();
    int nxt, h, v;
    bit tk, rdy, pat;
    logic [5:0] h6, v6;
    @(negedge clk);
    nxt = (m_pos + 1) % FRAME;
    tk  = (t % D) == D - 1;
    pat = PAT_EN && g_stp;
    rdy = tk && m_run && vis(nxt) && !pat;
    enable = g_en;
    show_test_pattern = g_stp;
    pix_valid = (g_valid_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 85);
    if (m_run && nxt == drop_pos) pix_valid = 1'b0;
    pix_data = inc_data ? data_ctr : 12'($urandom);
    underflow_clr = g_clr_rand ? ($urandom_range(0, 19) == 0) : g_clr_now;
    if (clr_on_drop && rdy && !pix_valid) underflow_clr = 1'b1;
    #1;
    check("pix_ready", pix_ready, rdy);
    if (pix_ready) rdy_cnt++;
    e_fs = 0;
    if (rdy && !pix_valid) e_uf = 1;
    else if (underflow_clr) e_uf = 0;
    if (tk) begin
      if (!m_run || m_pos == FRAME - 1) begin
        m_pos = 0;
        m_run = enable;
        if (!enable) begin e_hs = 0; e_vs = 0; e_pix = '0; end
      end else begin
        m_pos++;
      end
      if (m_run) begin
        h = m_pos % HT; v = m_pos / HT;
        h6 = h[5:0]; v6 = v[5:0];
        e_hs = h < HS;
        e_vs = v < VS;
        e_fs = (m_pos == 0);
        if (!vis(m_pos))    e_pix = '0;
        else if (pat)       e_pix = {v6, h6};
        else if (pix_valid) e_pix = pix_data;
        else                e_pix = '0;
      end
    end
    if (rdy && pix_valid && inc_data) data_ctr++;
    t++;
    @(posedge clk);
    #1;
    cyc++;
    check("cam_hsync", cam_hsync, e_hs);
    check("cam_vsync", cam_vsync, e_vs);
    check("cam_pixel", cam_pixel, e_pix);
    check("frame_start", frame_start, e_fs);
    check("underflow", underflow, e_uf);
    check("cam_clk", cam_clk, (t % D) >= D / 2);
    if (frame_start) begin
      fs_cnt++;
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc; since_fs = 0; base = data_ctr;
    end else begin
      since_fs++;
    end
    if (cam_hsync) hs_cyc++;
    if (cam_vsync) vs_cyc++;
    if (cam_clk && !prev_ck) ck_rise++;
    prev_ck = cam_clk;
    if (probe_on && since_fs >= 0 && since_fs % D == 0) begin
      for (int i = 0; i < 10; i++) begin
        if (tbl[i].v * HT + tbl[i].h == since_fs / D) begin
          probe_hits++;
          check("probe_hsync", cam_hsync, tbl[i].hs);
          check("probe_vsync", cam_vsync, tbl[i].vs);
          check("probe_pixel", cam_pixel, tbl[i].vis ? 32'(base + 12'(tbl[i].off)) : 32'd0);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int target, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (since_fs != target && n < 3000);
    check(name, since_fs, target);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_hsync"}, cam_hsync, 0);
    check({name, "_vsync"}, cam_vsync, 0);
    check({name, "_pixel"}, cam_pixel, 0);
    check({name, "_fs"}, frame_start, 0);
    check({name, "_uf"}, underflow, 0);
    check({name, "_camclk"}, cam_clk, 0);
    check({name, "_ready"}, pix_ready, 0);
  endtask

  initial begin
    int n, snap;
    tbl[0] = '{0, 0, 1, 1, 0, 0};
    tbl[1] = '{2, 0, 1, 1, 0, 0};
    tbl[2] = '{3, 0, 0, 1, 0, 0};
    tbl[3] = '{0, 1, 1, 1, 1, 0};
    tbl[4] = '{9, 1, 0, 1, 1, 9};
    tbl[5] = '{10, 1, 0, 1, 0, 0};
    tbl[6] = '{5, 2, 0, 0, 1, 15};
    tbl[7] = '{9, 6, 0, 0, 1, 59};
    tbl[8] = '{0, 7, 1, 0, 0, 0};
    tbl[9] = '{15, 8, 0, 0, 0, 0};

    rst = 1; enable = 0; pix_valid = 0; pix_data = '0;
    show_test_pattern = 0; underflow_clr = 0;
    g_en = 0; g_stp = 0; g_clr_rand = 0; g_clr_now = 0; clr_on_drop = 0; inc_data = 0;
    g_valid_mode = 0; drop_pos = -1; data_ctr = 12'h100; base = '0;
    cyc = 0; fs_cnt = 0; last_fs = -1; fs_period = 0; rdy_cnt = 0;
    hs_cyc = 0; vs_cyc = 0; ck_rise = 0; probe_hits = 0; probe_on = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // idle with enable low: only cam_clk moves
    run(20);

    // full frame, always valid, incrementing data
    g_en = 1; inc_data = 1;
    n = 0;
    while (fs_cnt == 0 && n < 20) begin step(); n++; end
    check("first_frame_start", fs_cnt, 1);
    probe_on = 1; rdy_cnt = 0; hs_cyc = 0; vs_cyc = 0; ck_rise = 0;
    run(FRAME * D);
    probe_on = 0;
    check("frame_count", fs_cnt, 2);
    check("frame_period", fs_period, FRAME * D);
    check("ready_per_frame", rdy_cnt, HA * VA);
    check("hsync_clks", hs_cyc, HS * D * VT);
    check("vsync_clks", vs_cyc, VS * HT * D);
    check("camclk_rises", ck_rise, FRAME);
    check("probe_hits", probe_hits, 10);

    // underflow on pixel 5 of line 3
    drop_pos = 3 * HT + 5;
    run_to(drop_pos * D, "reach_drop");
    check("drop_pixel", cam_pixel, 0);
    check("drop_underflow", underflow, 1);
    drop_pos = -1;
    run_to(53 * D + 100, "reach_hold");
    check("underflow_hold", underflow, 1);
    g_clr_now = 1; step(); g_clr_now = 0;
    check("underflow_cleared", underflow, 0);
    drop_pos = 5 * HT + 2; clr_on_drop = 1;
    run_to(drop_pos * D, "reach_setclr");
    check("setclr_underflow", underflow, 1);
    check("setclr_pixel", cam_pixel, 0);
    drop_pos = -1; clr_on_drop = 0;

    // enable dropped mid-frame: frame completes, then idle
    run_to(FRAME * D - 1, "reach_frame_end");
    snap = fs_cnt; hs_cyc = 0; vs_cyc = 0;
    run_to(4 * HT * D, "reach_line4");
    g_en = 0;
    run(1000);
    check("frames_after_drop", fs_cnt - snap, 1);
    check("full_frame_hsync", hs_cyc, HS * D * VT);
    check("full_frame_vsync", vs_cyc, VS * HT * D);
    ck_rise = 0;
    run(400);
    check("idle_camclk_rises", ck_rise, 100);
    check("idle_hsync", cam_hsync, 0);
    check("idle_vsync", cam_vsync, 0);
    check("idle_pixel", cam_pixel, 0);

    // re-enable restarts at (0,0)
    g_en = 1; snap = fs_cnt; n = 0;
    while (fs_cnt == snap && n < 2 * D) begin step(); n++; end
    check("restart_fs", fs_cnt - snap, 1);
    check("restart_hsync", cam_hsync, 1);
    check("restart_vsync", cam_vsync, 1);

    // async reset mid-line
    run(37);
    #2;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    step();
    check("restart_camclk_low", cam_clk, 0);
    run(FRAME * D);

    // randomized traffic against the model
    inc_data = 0; g_valid_mode = 1; g_clr_rand = 1;
    for (int blk = 0; blk < 12; blk++) begin
      g_en  = ($urandom_range(0, 3) != 0);
      g_stp = $urandom_range(0, 1);
      run(500);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
